// File: rtl/sensor_sample_sequencer_if.sv
// rtl/sensor_sample_sequencer_if.sv - Avalon-MM register bus bundle for the sensor sample sequencer
interface sensor_sample_sequencer_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/sensor_sample_sequencer.sv
// rtl/sensor_sample_sequencer.sv - timer-triggered ADC acquisition sequencer with sample FIFO; optional timestamps under SAMPLE_SEQ_TIMESTAMP_EN
module sensor_sample_sequencer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int ACQ_TIMEOUT = 1023
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            tick_in,
    sensor_sample_sequencer_if.slave        bus,
    output logic                            irq,
    output logic                            adc_start,
    input  logic                            adc_done,
    input  logic [15:0]                     adc_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
`ifdef SAMPLE_SEQ_TIMESTAMP_EN
    localparam int EW = 32;
`else
    localparam int EW = 16;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_STORE} state_t;

    state_t        state;
    state_t        state_nxt;

    logic [15:0]   wait_cnt;
    logic          wait_last;
    logic [15:0]   sample_q;

    logic          enable;
    logic          irq_en;
    logic          overrun;
    logic          timeout;
    logic          tick_q;
    logic          busy;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head_entry;

    logic          wr_en;
    logic          wr_status;
    logic          wr_control;
    logic          wr_data;
    logic          sw_trig;
    logic          tick_rise;
    logic          trig;
    logic          push;
    logic          pop;
    logic          store_drop;
    logic [15:0]   rd_mux;

    assign wr_en      = bus.chipselect & ~bus.write_n;
    assign wr_status  = wr_en & (bus.address == 3'd0);
    assign wr_control = wr_en & (bus.address == 3'd1);
    assign wr_data    = wr_en & (bus.address == 3'd2);

    assign sw_trig    = wr_control & bus.writedata[2];
    assign tick_rise  = tick_in & ~tick_q;
    assign trig       = enable & (tick_rise | sw_trig);

    assign empty      = (level == '0);
    assign full       = (level == LW'(FIFO_DEPTH));
    assign busy       = (state != S_IDLE);

    // A pop frees the head slot in the same cycle, so a full FIFO can still accept a store.
    assign pop        = wr_data & ~empty;
    assign push       = (state == S_STORE) & (~full | pop);
    assign store_drop = (state == S_STORE) & full & ~pop;

    // The counter holds the number of WAIT cycles already spent; this is the last allowed one.
    assign wait_last  = (({1'b0, wait_cnt} + 17'd1) == 17'(ACQ_TIMEOUT));

    assign head_entry = mem[rd_ptr];

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (trig) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (adc_done) begin
                    state_nxt = S_STORE;
                end else if (wait_last) begin
                    state_nxt = S_IDLE;
                end
            end
            S_STORE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        adc_start = (state == S_START);
    end

    // WAIT-cycle counter and sample capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            sample_q <= '0;
        end else begin
            if (state == S_START) begin
                wait_cnt <= '0;
            end else if ((state == S_WAIT) && !adc_done) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if ((state == S_WAIT) && adc_done) begin
                sample_q <= adc_data;
            end
        end
    end

`ifdef SAMPLE_SEQ_TIMESTAMP_EN
    logic [15:0] ts_cnt;
    logic [15:0] ts_q;

    // Free-running cycle counter, snapshotted when the conversion is requested
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
            if (state == S_START) begin
                ts_q <= ts_cnt;
            end
        end
    end

    assign push_entry = {ts_q, sample_q};
`else
    assign push_entry = sample_q;
`endif

    // CONTROL register and tick edge detector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable <= 1'b0;
            irq_en <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_in;
            if (wr_control) begin
                enable <= bus.writedata[0];
                irq_en <= bus.writedata[1];
            end
        end
    end

    // Sticky error flags; a new event in the same cycle as a STATUS write wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if ((trig && busy) || store_drop) begin
                overrun <= 1'b1;
            end else if (wr_status) begin
                overrun <= 1'b0;
            end
            if ((state == S_WAIT) && !adc_done && wait_last) begin
                timeout <= 1'b1;
            end else if (wr_status) begin
                timeout <= 1'b0;
            end
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Register read mux
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            3'd0: rd_mux = {4'b0, 4'(level), 3'b0, busy, timeout, overrun, full, empty};
            3'd1: rd_mux = {14'b0, irq_en, enable};
            3'd2: rd_mux = empty ? 16'h0000 : head_entry[15:0];
`ifdef SAMPLE_SEQ_TIMESTAMP_EN
            3'd3: rd_mux = empty ? 16'h0000 : head_entry[31:16];
`endif
            default: rd_mux = '0;
        endcase
    end

    // Registered read data and interrupt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            bus.readdata <= rd_mux;
            irq          <= irq_en & (~empty | overrun | timeout);
        end
    end
endmodule
